// File: rtl/prim_clkgate_pkg.sv
// Shared types and sizing helpers for the MAC clock-gate enable sequencer.
package prim_clkgate_pkg;

    typedef enum logic [1:0] {CgOff, CgWake, CgOn, CgHold} cg_state_e;

    // Wait counter must hold the larger of the two load values.
    function automatic int unsigned wait_cnt_w(input int unsigned wake, input int unsigned hold);
        int unsigned m;
        m = (wake > hold) ? wake : hold;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int unsigned DefaultWaitCntW = wait_cnt_w(2, 4);

endpackage

// File: rtl/prim_clock_gate_ctrl_if.sv
// Core-side request/enable bundle of the clock-gate enable sequencer.
interface prim_clock_gate_ctrl_if #(
    parameter int unsigned StatW = 32
);
    logic             req_i;
    logic             busy_i;
    logic             force_on_i;
    logic             stat_clr_i;
    logic             en_o;
    logic             gnt_o;
    logic             idle_o;
    logic [StatW-1:0] stat_cnt_o;

    modport master (
        output req_i, busy_i, force_on_i, stat_clr_i,
        input  en_o, gnt_o, idle_o, stat_cnt_o
    );

    modport slave (
        input  req_i, busy_i, force_on_i, stat_clr_i,
        output en_o, gnt_o, idle_o, stat_cnt_o
    );
endinterface

// File: rtl/prim_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prim_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_clock_gate_ctrl.sv
// Enable sequencer for the MAC clock-gate cell: wake delay before grant,
// idle hysteresis before gating off, and enabled-cycle statistics.
module prim_clock_gate_ctrl
    import prim_clkgate_pkg::*;
#(
    parameter int unsigned WakeCycles     = 2,
    parameter int unsigned IdleHoldCycles = 4,
    parameter int unsigned StatW          = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    prim_clock_gate_ctrl_if.slave  cg
);
    localparam int unsigned CntW     = wait_cnt_w(WakeCycles, IdleHoldCycles);
    localparam int unsigned WakeLoad = (WakeCycles > 0) ? WakeCycles - 1 : 0;
    localparam int unsigned HoldLoad = (IdleHoldCycles > 0) ? IdleHoldCycles - 1 : 0;

    cg_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            en_q, en_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CgOff;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CgOff: begin
                if (cg.req_i) begin
                    state_d = CgWake;
                    cnt_d   = CntW'(WakeLoad);
                end
            end
            // A dropped request during wake still completes; ON then falls to HOLD.
            CgWake: begin
                if (cnt_q == '0) state_d = CgOn;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            CgOn: begin
                if (!cg.req_i && !cg.busy_i) begin
                    if (IdleHoldCycles == 0) begin
                        state_d = CgOff;
                    end else begin
                        state_d = CgHold;
                        cnt_d   = CntW'(HoldLoad);
                    end
                end
            end
            CgHold: begin
                if (cg.req_i || cg.busy_i) state_d = CgOn;
                else if (cnt_q == '0)      state_d = CgOff;
                else                       cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = CgOff;
        endcase
        // Registered so the gate cell only ever sees a clean flop output.
        en_d = (state_d != CgOff) || cg.force_on_i;
    end

    always_comb begin
        cg.gnt_o  = (state_q == CgOn) && cg.req_i;
        cg.idle_o = (state_q == CgOff) && !cg.busy_i;
        cg.en_o   = en_q;
    end

    prim_sat_counter #(
        .Width (StatW)
    ) u_stat (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (en_q),
        .clr_i  (cg.stat_clr_i),
        .cnt_o  (cg.stat_cnt_o)
    );

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Scoreboard bench: two configurations (W2/H4/32b and W3/H0/4b) against a
// cycle-level power/readiness model of the enable sequencer.
module tb_prim_clock_gate_ctrl;

    typedef struct packed {
        logic        en;
        logic        gnt;
        logic        idle;
        logic [31:0] stat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] s_req, s_busy, s_force, s_clr;

    prim_clock_gate_ctrl_if #(.StatW(32)) ifa ();
    prim_clock_gate_ctrl_if #(.StatW(4))  ifb ();

    assign ifa.req_i      = s_req[0];
    assign ifa.busy_i     = s_busy[0];
    assign ifa.force_on_i = s_force[0];
    assign ifa.stat_clr_i = s_clr[0];
    assign ifb.req_i      = s_req[1];
    assign ifb.busy_i     = s_busy[1];
    assign ifb.force_on_i = s_force[1];
    assign ifb.stat_clr_i = s_clr[1];

    prim_clock_gate_ctrl #(.WakeCycles(2), .IdleHoldCycles(4), .StatW(32)) dut_a (
        .clk_i (clk), .rst_ni (rst_n), .cg (ifa)
    );
    prim_clock_gate_ctrl #(.WakeCycles(3), .IdleHoldCycles(0), .StatW(4)) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .cg (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "powered" = sequencer not gated off, "age" = powered
    // cycles elapsed since wake began, "quiet" = consecutive idle cycles once ready.
    int unsigned mw[2];
    int unsigned mih[2];
    logic [31:0] mmax[2];
    bit          m_pow[2];
    int unsigned m_age[2];
    int unsigned m_quiet[2];
    bit          m_en[2];
    logic [31:0] m_stat[2];
    bit          last_gnt[2];

    exp_t sbq0[$];
    exp_t sbq1[$];

    int n_vec  = 0;
    int n_miss = 0;
    int en_run[2];

    task automatic apply(input logic [1:0] rq, input logic [1:0] bz, input logic [1:0] fo,
                         input logic [1:0] cl, input logic rn);
        s_req = rq; s_busy = bz; s_force = fo; s_clr = cl; rst_n = rn;
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit   ready;
            ready  = m_pow[d] && (m_age[d] >= mw[d]);
            e.en   = m_en[d];
            e.gnt  = ready && (m_quiet[d] == 0) && rq[d];
            e.idle = !m_pow[d] && !bz[d];
            e.stat = m_stat[d];
            if (d == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
            last_gnt[d] = e.gnt;
            if (!rn) begin
                m_pow[d] = 0; m_en[d] = 0; m_stat[d] = 0; m_age[d] = 0; m_quiet[d] = 0;
            end else begin
                if (cl[d])                             m_stat[d] = 0;
                else if (m_en[d] && m_stat[d] != mmax[d]) m_stat[d] = m_stat[d] + 1;
                if (!m_pow[d]) begin
                    if (rq[d]) begin
                        m_pow[d] = 1; m_age[d] = 0; m_quiet[d] = 0;
                    end
                end else if (ready) begin
                    m_quiet[d] = (rq[d] || bz[d]) ? 0 : m_quiet[d] + 1;
                    if (m_quiet[d] == mih[d] + 1) m_pow[d] = 0;
                end else begin
                    m_age[d] = m_age[d] + 1;
                end
                m_en[d] = m_pow[d] || fo[d];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input int n, input logic [1:0] rq, input logic [1:0] fo,
                       input logic [1:0] cl, input logic rn);
        for (int i = 0; i < n; i++) apply(rq, 2'b00, fo, cl, rn);
    endtask

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, want, $time);
        end
    endtask

    task automatic cmp(input int d, input logic en, input logic gnt, input logic idle,
                       input logic [31:0] stat);
        exp_t e;
        bit   have;
        have = 0;
        if (d == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1; end
        if (d == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1; end
        if (have) begin
            chk(d, "en_o",       32'(en),   32'(e.en));
            chk(d, "gnt_o",      32'(gnt),  32'(e.gnt));
            chk(d, "idle_o",     32'(idle), 32'(e.idle));
            chk(d, "stat_cnt_o", stat,      e.stat);
            // Grant must follow at least WakeCycles consecutive enabled cycles.
            if (gnt === 1'b1) chk(d, "gnt_wake_ok", 32'(en_run[d] >= int'(mw[d])), 32'd1);
        end
        en_run[d] = (en === 1'b1) ? en_run[d] + 1 : 0;
    endtask

    always @(negedge clk) begin
        cmp(0, ifa.en_o, ifa.gnt_o, ifa.idle_o, ifa.stat_cnt_o);
        cmp(1, ifb.en_o, ifb.gnt_o, ifb.idle_o, 32'(ifb.stat_cnt_o));
    end

    initial begin
        logic [1:0] rq, bz, fo, cl;
        logic       rn;
        int         act;
        mw[0] = 2; mih[0] = 4; mmax[0] = 32'hFFFF_FFFF;
        mw[1] = 3; mih[1] = 0; mmax[1] = 32'd15;
        for (int d = 0; d < 2; d++) begin
            m_pow[d] = 0; m_en[d] = 0; m_stat[d] = 0; m_age[d] = 0;
            m_quiet[d] = 0; last_gnt[d] = 0; en_run[d] = 0;
        end
        s_req = '0; s_busy = '0; s_force = '0; s_clr = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed: wake latency, hold window, reactivation from hold, force/saturate, clear, reset in ON.
        dir(1, 2'b00, 2'b00, 2'b00, 1'b0);
        dir(6, 2'b11, 2'b00, 2'b00, 1'b1);
        dir(8, 2'b00, 2'b00, 2'b00, 1'b1);
        dir(5, 2'b11, 2'b00, 2'b00, 1'b1);
        dir(3, 2'b00, 2'b00, 2'b00, 1'b1);
        dir(3, 2'b11, 2'b00, 2'b00, 1'b1);
        dir(8, 2'b00, 2'b00, 2'b00, 1'b1);
        dir(10, 2'b00, 2'b11, 2'b00, 1'b1);
        dir(2, 2'b00, 2'b00, 2'b00, 1'b1);
        dir(20, 2'b00, 2'b11, 2'b00, 1'b1);
        dir(1, 2'b00, 2'b11, 2'b11, 1'b1);
        dir(4, 2'b00, 2'b00, 2'b00, 1'b1);
        dir(6, 2'b11, 2'b00, 2'b00, 1'b1);
        dir(1, 2'b11, 2'b00, 2'b00, 1'b0);
        dir(3, 2'b00, 2'b00, 2'b00, 1'b1);

        // Random: requests held until granted, busy only while powered.
        fo  = '0;
        act = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) act = $urandom_range(1, 12);
            for (int d = 0; d < 2; d++) begin
                rq[d] = (s_req[d] && !last_gnt[d]) ? 1'b1 : ($urandom_range(0, act) == 0);
                bz[d] = m_pow[d] ? ($urandom_range(0, act) == 0) : 1'b0;
                if ($urandom_range(0, 99) == 0) fo[d] = ~fo[d];
                cl[d] = ($urandom_range(0, 63) == 0);
            end
            rn = ($urandom_range(0, 299) != 0);
            apply(rq, bz, fo, cl, rn);
        end
        s_req = '0; s_busy = '0; s_force = '0; s_clr = '0;

        repeat (3) @(negedge clk);
        if (sbq0.size() != 0 || sbq1.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d/%0d expected entries left unchecked", sbq0.size(), sbq1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
